// File: rtl/text_ram_sched_pkg.sv
// Shared constants, state encoding and port payload for the text RAM scheduler.
// Operand-bus addresses, CTL field positions and bulk-operation codes live here.
package text_ram_sched_pkg;

    localparam logic [31:0] VIDEO_ADDR = 32'h0000_F000;
    localparam logic [31:0] TEXT_BASE  = VIDEO_ADDR + 32'h10;
    localparam logic [31:0] CTL_ADDR   = VIDEO_ADDR + 32'h3;

    localparam int unsigned COLS  = 80;
    localparam int unsigned ROWS  = 40;
    localparam int unsigned AW    = 12;
    localparam int unsigned CELLS = COLS * ROWS;

    localparam logic [1:0] TEXT_OP_NOP    = 2'd0;
    localparam logic [1:0] TEXT_OP_CLEAR  = 2'd1;
    localparam logic [1:0] TEXT_OP_SCROLL = 2'd2;

    localparam int unsigned CTL_BUSY_BIT = 1;
    localparam int unsigned CTL_OP_LSB   = 0;
    localparam int unsigned CTL_FILL_LSB = 8;

    localparam logic [7:0]    FILL_RESET = 8'h20;
    localparam logic [AW-1:0] LAST_CELL  = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_MOVE  = AW'((ROWS - 1) * COLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_FILL
    } eng_state_e;

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } ram_req_t;

endpackage

// File: rtl/text_move_engine.sv
// Bulk clear / scroll-up engine; requests the text RAM port and only advances
// when granted, so the core can steal any cycle without corrupting the run.
module text_move_engine
    import text_ram_sched_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [7:0]    fill,
    input  logic          gnt,
    input  logic [7:0]    ram_rdata,
    output logic          eng_req,
    output logic          eng_we,
    output logic [AW-1:0] eng_addr,
    output logic [7:0]    eng_wdata,
    output logic          busy
);

    eng_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    latch_q;
    logic          rd_pend_q;

    // State, pointer and scroll read latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            latch_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rd_pend_q <= (state_q == ST_SCR_RD) && gnt;
            // Captured whether or not the engine owns the port this cycle
            if (rd_pend_q) begin
                latch_q <= ram_rdata;
            end
        end
    end

    // Next state and port request
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        eng_req   = 1'b0;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && op == TEXT_OP_CLEAR) begin
                    state_d = ST_CLR;
                    ptr_d   = '0;
                end else if (start && op == TEXT_OP_SCROLL) begin
                    state_d = ST_SCR_RD;
                    ptr_d   = '0;
                end
            end
            ST_CLR, ST_FILL: begin
                eng_req   = 1'b1;
                eng_we    = 1'b1;
                eng_addr  = ptr_q;
                eng_wdata = fill;
                if (gnt) begin
                    if (ptr_q == LAST_CELL) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            ST_SCR_RD: begin
                eng_req  = 1'b1;
                eng_addr = ptr_q + AW'(COLS);
                if (gnt) begin
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                eng_req  = 1'b1;
                eng_we   = 1'b1;
                eng_addr = ptr_q;
                // Read data is still on the RAM output right after our read
                eng_wdata = rd_pend_q ? ram_rdata : latch_q;
                if (gnt) begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = (ptr_q == LAST_MOVE) ? ST_FILL : ST_SCR_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/text_ram_sched.sv
// Arbiter for the text RAM write port: core operand accesses always win,
// the bulk engine uses the remaining cycles; hosts the CTL/status register.
module text_ram_sched
    import text_ram_sched_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_en,
    input  logic          cpu_rw,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rvalid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic          busy
);

    logic [31:0]   offset;
    logic          text_hit;
    logic          ctl_hit;
    logic          ctl_wr_ok;
    logic          gnt;
    logic [7:0]    fill_q;
    logic          rvalid_q;
    logic          rd_ctl_q;
    logic          busy_q;
    logic          eng_req;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [7:0]    eng_wdata;
    ram_req_t      eng_port;
    ram_req_t      port;
    logic          unused_bits;

    // Operand address decode; nothing reaches the RAM while in reset
    assign offset    = cpu_addr - TEXT_BASE;
    assign text_hit  = !reset && cpu_en && (cpu_addr >= TEXT_BASE)
                       && (cpu_addr < TEXT_BASE + 32'(CELLS));
    assign ctl_hit   = !reset && cpu_en && (cpu_addr == CTL_ADDR);
    assign ctl_wr_ok = ctl_hit && cpu_rw && !busy;
    assign gnt       = !text_hit;

    assign unused_bits = ^{cpu_wdata[31:16], offset[31:AW]};

    text_move_engine u_engine (
        .clk       (clk),
        .reset     (reset),
        .start     (ctl_wr_ok),
        .op        (cpu_wdata[CTL_OP_LSB +: 2]),
        .fill      (fill_q),
        .gnt       (gnt),
        .ram_rdata (ram_rdata),
        .eng_req   (eng_req),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .busy      (busy)
    );

    assign eng_port = {eng_req, eng_we, eng_addr, eng_wdata};

    // Core-priority port mux
    always_comb begin
        port = eng_port;
        if (text_hit) begin
            port.en    = 1'b1;
            port.we    = cpu_rw;
            port.addr  = offset[AW-1:0];
            port.wdata = cpu_rw ? cpu_wdata[7:0] : 8'h00;
        end
    end

    assign ram_en    = port.en;
    assign ram_we    = port.we;
    assign ram_addr  = port.addr;
    assign ram_wdata = port.wdata;

    // Fill character and read-response pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q   <= FILL_RESET;
            rvalid_q <= 1'b0;
            rd_ctl_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rvalid_q <= (text_hit || ctl_hit) && !cpu_rw;
            rd_ctl_q <= ctl_hit && !cpu_rw;
            busy_q   <= busy;
            if (ctl_wr_ok) begin
                fill_q <= cpu_wdata[CTL_FILL_LSB +: 8];
            end
        end
    end

    // Cell data arrives from the RAM in the response cycle
    always_comb begin
        cpu_rdata = 32'h0;
        if (rvalid_q) begin
            if (rd_ctl_q) begin
                cpu_rdata = 32'(busy_q) << CTL_BUSY_BIT;
            end else begin
                cpu_rdata = {24'h0, ram_rdata};
            end
        end
    end

    assign cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_text_ram_sched.sv
// Directed bench for text_ram_sched with a behavioural one-cycle-latency text RAM.
module tb_text_ram_sched;
    import text_ram_sched_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_en;
    logic          cpu_rw;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_rvalid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          busy;

    logic [7:0] mem [0:CELLS-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_ram_sched dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata);
        cpu_en    = en;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic preload_index();
        for (int i = 0; i < int'(CELLS); i++) begin
            drive(1'b1, 1'b1, TEXT_BASE + 32'(i), 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || ram_en !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b ram_en=%b rvalid=%b rdata=%h, required all 0",
                     busy, ram_en, cpu_rvalid, cpu_rdata);
        end
        reset = 1'b0;
        tick();
        drive(1'b1, 1'b0, CTL_ADDR, 32'h0);
        #1;
        checks++;
        if (ram_en !== 1'b0) begin
            errors++;
            $display("FAIL ctl_read_no_ram: ram_en=%b required 0", ram_en);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL ctl_read_idle: rvalid=%b rdata=%h required 1 / 00000000",
                     cpu_rvalid, cpu_rdata);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse: rvalid=%b required 0", cpu_rvalid);
        end
    endtask

    task automatic test_cell_rw();
        drive(1'b1, 1'b1, TEXT_BASE + 32'd5, 32'hFFFF_FF41);
        #1;
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(5) || ram_wdata !== 8'h41) begin
            errors++;
            $display("FAIL cell_write_port: en=%b we=%b addr=%0d wdata=%h required 1/1/5/41",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        tick();
        drive(1'b1, 1'b0, TEXT_BASE + 32'd5, 32'h0);
        #1;
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AW'(5)) begin
            errors++;
            $display("FAIL cell_read_port: en=%b we=%b addr=%0d required 1/0/5",
                     ram_en, ram_we, ram_addr);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h41) begin
            errors++;
            $display("FAIL cell_readback: rvalid=%b rdata=%h required 1 / 00000041",
                     cpu_rvalid, cpu_rdata);
        end
        drive(1'b1, 1'b1, TEXT_BASE + 32'(CELLS - 1), 32'h7E);
        #1;
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== AW'(CELLS - 1) || ram_wdata !== 8'h7E) begin
            errors++;
            $display("FAIL last_cell_write: en=%b addr=%0d wdata=%h required 1/3199/7e",
                     ram_en, ram_addr, ram_wdata);
        end
        tick();
        drive(1'b1, 1'b0, TEXT_BASE + 32'(CELLS), 32'h0);
        #1;
        checks++;
        if (ram_en !== 1'b0) begin
            errors++;
            $display("FAIL past_window: ram_en=%b required 0", ram_en);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL past_window_rvalid: rvalid=%b required 0", cpu_rvalid);
        end
    endtask

    task automatic test_clear();
        int n;
        int bad;
        drive(1'b1, 1'b1, CTL_ADDR, 32'h2E01);
        tick();
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            if (n == 201) begin
                checks++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h2) begin
                    errors++;
                    $display("FAIL ctl_read_busy: rvalid=%b rdata=%h required 1 / 00000002",
                             cpu_rvalid, cpu_rdata);
                end
            end
            if (n == 100)      drive(1'b1, 1'b1, CTL_ADDR, 32'h0000_0002);
            else if (n == 200) drive(1'b1, 1'b0, CTL_ADDR, 32'h0);
            else               drive(1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            if (n == 0) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== AW'(0) || ram_wdata !== 8'h2E) begin
                    errors++;
                    $display("FAIL clear_first_write: we=%b addr=%0d wdata=%h required 1/0/2e",
                             ram_we, ram_addr, ram_wdata);
                end
            end
            n++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (n != 3200) begin
            errors++;
            $display("FAIL clear_duration: busy cycles=%0d required 3200", n);
        end
        bad = 0;
        for (int i = 0; i < int'(CELLS); i++) if (mem[i] !== 8'h2E) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_image: %0d cells differ from 2e, required 0", bad);
        end
    endtask

    task automatic test_scroll();
        int n;
        int bad;
        logic [7:0] exp;
        preload_index();
        drive(1'b1, 1'b1, CTL_ADDR, 32'h2002);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AW'(80)) begin
            errors++;
            $display("FAIL scroll_first_read: en=%b we=%b addr=%0d required 1/0/80",
                     ram_en, ram_we, ram_addr);
        end
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(0) || ram_wdata !== 8'h50) begin
            errors++;
            $display("FAIL scroll_first_write: we=%b addr=%0d wdata=%h required 1/0/50",
                     ram_we, ram_addr, ram_wdata);
        end
        n = 1;
        while (busy === 1'b1 && n < 8000) begin
            n++;
            tick();
        end
        checks++;
        if (n != 6320) begin
            errors++;
            $display("FAIL scroll_duration: busy cycles=%0d required 6320", n);
        end
        bad = 0;
        for (int i = 0; i < int'(CELLS); i++) begin
            exp = (i < 3120) ? 8'(i + 80) : 8'h20;
            if (mem[i] !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL scroll_image: %0d cells wrong, required 0", bad);
        end
    endtask

    task automatic test_scroll_contended();
        int n;
        int bad;
        logic pend;
        logic [31:0] exp_rd;
        logic [7:0] exp;
        preload_index();
        drive(1'b1, 1'b1, CTL_ADDR, 32'h2002);
        tick();
        n = 0;
        pend = 1'b0;
        exp_rd = 32'h0;
        while (busy === 1'b1 && n < 12000) begin
            if (pend) begin
                checks++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL contended_read n=%0d: rvalid=%b rdata=%h required 1 / %h",
                             n, cpu_rvalid, cpu_rdata, exp_rd);
                end
            end
            pend = 1'b0;
            // Extra read at 11 shifts the core into the slot right after an engine read
            if (n % 3 == 0 || n == 11) begin
                drive(1'b1, 1'b0, TEXT_BASE, 32'h0);
                pend = 1'b1;
                exp_rd = (n == 0) ? 32'h0 : 32'h50;
            end else begin
                drive(1'b0, 1'b0, 32'h0, 32'h0);
            end
            n++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        if (pend) begin
            checks++;
            if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_rd) begin
                errors++;
                $display("FAIL contended_last_read: rvalid=%b rdata=%h required 1 / %h",
                         cpu_rvalid, cpu_rdata, exp_rd);
            end
        end
        checks++;
        if (n != 9482) begin
            errors++;
            $display("FAIL contended_duration: busy cycles=%0d required 9482", n);
        end
        bad = 0;
        for (int i = 0; i < int'(CELLS); i++) begin
            exp = (i < 3120) ? 8'(i + 80) : 8'h20;
            if (mem[i] !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL contended_image: %0d cells wrong, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        logic [7:0] exp;
        drive(1'b1, 1'b1, CTL_ADDR, 32'h5501);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (1000) tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(1000)) begin
            errors++;
            $display("FAIL clear_at_1000: we=%b addr=%0d required 1/1000", ram_we, ram_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 ||
            ram_wdata !== 8'h0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b en=%b we=%b addr=%0d wd=%h rv=%b rd=%h required all 0",
                     busy, ram_en, ram_we, ram_addr, ram_wdata, cpu_rvalid, cpu_rdata);
        end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (i < 1000)      exp = 8'h55;
            else if (i < 3120) exp = 8'(i + 80);
            else               exp = 8'h20;
            if (mem[i] !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL partial_image: %0d cells wrong, required 0", bad);
        end
        tick();
        drive(1'b1, 1'b1, CTL_ADDR, 32'h3301);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(0) || ram_wdata !== 8'h33) begin
            errors++;
            $display("FAIL restart_from_0: we=%b addr=%0d wdata=%h required 1/0/33",
                     ram_we, ram_addr, ram_wdata);
        end
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            n++;
            tick();
        end
        checks++;
        if (n != 3200) begin
            errors++;
            $display("FAIL restart_duration: busy cycles=%0d required 3200", n);
        end
        bad = 0;
        for (int i = 0; i < int'(CELLS); i++) if (mem[i] !== 8'h33) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_image: %0d cells differ from 33, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_cell_rw();
        test_clear();
        test_scroll();
        test_scroll_contended();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_ram_sched.md
Name: text_ram_sched

Overview:
- Schedules the single write-capable port of the 80x40 VGA text RAM.
- Shares that port between core operand-bus accesses and a built-in bulk engine that performs clear-screen and scroll-up-one-row.
- Sits between the core operand bus and port B of the text RAM wrapper, replacing the core's direct connection to that port.
- Exposes one control/status MMR so software can start bulk operations and poll completion.

Parameters:
- TEXT_BASE, `VIDEO_ADDR + 'h10: operand address of text cell 0.
- CTL_ADDR, `VIDEO_ADDR + 3: operand address of the control/status register.
- COLS, 80: cells per row.
- ROWS, 40: rows.
- AW, 12: text RAM address width; COLS*ROWS must be <= 2**AW.

Ports:
- clk  in  1  core/datamem clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpu_en  in  1  core operand access valid this cycle.
- cpu_rw  in  1  1 = write, 0 = read (operand-bus convention).
- cpu_addr  in  32  operand address.
- cpu_wdata  in  32  write data; only bits [7:0] are stored in cells.
- cpu_rdata  out  32  read data; valid when cpu_rvalid is high.
- cpu_rvalid  out  1  pulses one cycle after an accepted read of a cell or CTL_ADDR.
- ram_en  out  1  text RAM port enable.
- ram_we  out  1  text RAM write enable.
- ram_addr  out  AW  text RAM address.
- ram_wdata  out  8  text RAM write data.
- ram_rdata  in  8  text RAM read data, one-cycle latency after ram_en with ram_we low.
- busy  out  1  bulk engine active.

Behaviour:
- Reset values: all outputs 0; state IDLE; ptr 0; fill char 8'h20. Reset mid-operation aborts immediately and leaves RAM contents partial.
- Core text hit: cpu_en high and TEXT_BASE <= cpu_addr < TEXT_BASE+COLS*ROWS.
  - Index = cpu_addr - TEXT_BASE.
  - The core always wins the port in the same cycle, combinationally.
  - The engine holds its state and ptr that cycle.
- Core CTL hit: cpu_en high and cpu_addr == CTL_ADDR.
  - Write is accepted only when busy is 0. wdata[1:0] = op (0 nop, 1 CLEAR, 2 SCROLL, 3 reserved/nop); wdata[15:8] = fill char.
  - Write while busy is ignored silently.
  - Read returns {30'b0, busy, 1'b0} after one cycle, flagged by cpu_rvalid.
- Core access to any other address: no RAM access, no rvalid.
- Core cell read: cpu_rdata = {24'b0, ram_rdata} in the following cycle, with cpu_rvalid high.
- FSM states: IDLE, CLR, SCR_RD, SCR_WR, FILL.
- IDLE:
  - op CLEAR -> CLR, ptr = 0.
  - op SCROLL -> SCR_RD, ptr = 0.
  - busy = 0 only in IDLE.
- CLR: write fill to ptr, ptr++. After writing COLS*ROWS-1 -> IDLE.
- SCR_RD: read ptr+COLS -> SCR_WR.
- SCR_WR:
  - The data read in the previous granted SCR_RD is latched unconditionally the cycle after that read issues, even if the core takes the port in that cycle.
  - Write the latch to ptr, ptr++.
  - After ptr (ROWS-1)*COLS-1 -> FILL; otherwise -> SCR_RD.
- FILL: write fill char to ptr, ptr++. After COLS*ROWS-1 -> IDLE.
- Engine transitions and ptr advance happen only in cycles the engine owns the port.
- Uncontended durations:
  - CLEAR = COLS*ROWS cycles (3200).
  - SCROLL = 2*(ROWS-1)*COLS + COLS cycles (6320).
- busy falls the cycle after the last engine write.
- Core writes into the text window during an engine run are performed. They may later be overwritten by the engine; software must poll busy first.
- ptr never exceeds COLS*ROWS-1; no wrap-around path exists.

Decomposition:
- common.vh: VIDEO_ADDR, TEXT_OP_NOP/CLEAR/SCROLL codes, CTL bit positions (busy = bit 1, op = bits [1:0] on write, fill = bits [15:8]).
- Sub-module text_move_engine: FSM, ptr, read latch, and engine request signals (eng_req, eng_we, eng_addr, eng_wdata, gnt input).
- text_ram_sched: address decode, core-priority mux, CTL register, rdata/rvalid pipeline.

Test Plan:
- After reset: busy = 0, ram_en = 0; read CTL_ADDR -> cpu_rdata = 0, cpu_rvalid one cycle later.
- Write 8'h41 to TEXT_BASE+5, then read it -> ram_we/ram_addr = 5/ram_wdata = 8'h41; readback cpu_rdata = 32'h41 one cycle after the read.
- Write CTL = 32'h2E01 -> busy for exactly 3200 cycles; every cell = 8'h2E; write CTL = 2 mid-run is ignored.
- Preload cell i = i[7:0], write CTL = 32'h2002 -> after 6320 cycles cell i = (i+80)[7:0] for i < 3120, and cells 3120..3199 = 8'h20.
- During SCROLL, core reads TEXT_BASE every third cycle -> engine stalls only on those cycles, final image identical to uncontended run, each core read returns correct data.
- Assert reset for 1 cycle mid-CLEAR at ptr = 1000 -> busy = 0 and outputs 0 immediately; cells >= 1000 retain old values; a new CLEAR starts from ptr 0.
